// File: rtl/mem_stage.sv
// RISC-V MEM stage: EX/MEM + MEM/WB registers, req/ack data port with lane alignment, load extension, bus timeout.
// Latency: 1 cycle EX->MEM, 1 cycle MEM->WB; a memory op adds one stall per cycle without dmem_ack.
// Backpressure: combinational stall_mem freezes upstream and EX/MEM and bubbles WB; MEM_MISALIGN_TRAP_EN adds misalign trapping.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResult_ex,
  input  logic [31:0] MemWriteData_ex,
  input  logic [4:0]  rdAddr_ex,
  input  logic        RegWrite_ex,
  input  logic        MemRead_ex,
  input  logic        MemWrite_ex,
  input  logic        MemtoReg_ex,
  input  logic [2:0]  funct3_ex,
  output logic [31:0] ALUResult_mem,
  output logic [4:0]  rdAddr_mem,
  output logic        RegWrite_mem,
  output logic        stall_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] RegWriteData_wb,
  output logic [4:0]  rdAddr_wb,
  output logic        RegWrite_wb,
  output logic        bus_err_mem
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign_mem
`endif
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {IDLE, WAIT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [31:0] wdata_mem;
  logic        MemRead_mem;
  logic        MemWrite_mem;
  logic        MemtoReg_mem;
  logic [2:0]  funct3_mem;

  logic [1:0]  a;
  logic [1:0]  size;
  logic        memop_raw;
  logic        memop;
  logic        ack_ok;
  logic        timeout;
  logic        complete;
  logic [3:0]  be_c;
  logic [31:0] wd_c;
  logic [31:0] rdata_eff;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic        wb_rw;

  // EX/MEM register
  always_ff @(posedge clk) begin
    if (reset) begin
      ALUResult_mem <= '0;
      wdata_mem     <= '0;
      rdAddr_mem    <= '0;
      RegWrite_mem  <= 1'b0;
      MemRead_mem   <= 1'b0;
      MemWrite_mem  <= 1'b0;
      MemtoReg_mem  <= 1'b0;
      funct3_mem    <= '0;
    end else if (!stall_mem) begin
      ALUResult_mem <= ALUResult_ex;
      wdata_mem     <= MemWriteData_ex;
      rdAddr_mem    <= rdAddr_ex;
      RegWrite_mem  <= RegWrite_ex;
      MemRead_mem   <= MemRead_ex;
      MemWrite_mem  <= MemWrite_ex;
      MemtoReg_mem  <= MemtoReg_ex;
      funct3_mem    <= funct3_ex;
    end
  end

  // funct3[1:0] gives size for loads and stores alike: 00 byte, 01 half, else word
  assign a         = ALUResult_mem[1:0];
  assign size      = funct3_mem[1:0];
  assign memop_raw = MemRead_mem | MemWrite_mem;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  always_comb begin
    misaligned = 1'b0;
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = a[0];
      default: misaligned = (a != 2'b00);
    endcase
  end
  assign memop        = memop_raw & ~misaligned;
  assign misalign_mem = memop_raw & misaligned;
  assign wb_rw        = RegWrite_mem & ~misaligned;
`else
  assign memop = memop_raw;
  assign wb_rw = RegWrite_mem;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dmem_req = 1'b0;
    ack_ok   = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        if (memop) begin
          dmem_req = 1'b1;
          if (dmem_ack) begin
            ack_ok = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end
      end
      WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          ack_ok  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign complete    = ack_ok | timeout;
  assign stall_mem   = memop & ~complete;
  assign bus_err_mem = timeout;

  // Store lane steering; low address bits beyond the access size are ignored
  always_comb begin
    be_c = 4'b1111;
    wd_c = wdata_mem;
    case (size)
      2'b00: begin
        be_c = 4'b0001 << a;
        wd_c = {4{wdata_mem[7:0]}};
      end
      2'b01: begin
        be_c = 4'b0011 << {a[1], 1'b0};
        wd_c = {2{wdata_mem[15:0]}};
      end
      default: begin
        be_c = 4'b1111;
        wd_c = wdata_mem;
      end
    endcase
  end

  assign dmem_addr  = {ALUResult_mem[31:2], 2'b00};
  assign dmem_we    = dmem_req & MemWrite_mem;
  assign dmem_be    = dmem_req ? be_c : 4'b0000;
  assign dmem_wdata = dmem_req ? wd_c : 32'h0;

  // A timed-out access returns zero data
  assign rdata_eff = timeout ? 32'h0 : dmem_rdata;

  always_comb begin
    byte_sel = rdata_eff[7:0];
    case (a)
      2'd0: byte_sel = rdata_eff[7:0];
      2'd1: byte_sel = rdata_eff[15:8];
      2'd2: byte_sel = rdata_eff[23:16];
      2'd3: byte_sel = rdata_eff[31:24];
      default: byte_sel = rdata_eff[7:0];
    endcase
    half_sel = a[1] ? rdata_eff[31:16] : rdata_eff[15:0];
    case (size)
      2'b00:   load_ext = {{24{~funct3_mem[2] & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{~funct3_mem[2] & half_sel[15]}}, half_sel};
      default: load_ext = rdata_eff;
    endcase
  end

  // MEM/WB register: stalls inject a bubble, data fields hold
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteData_wb <= '0;
      rdAddr_wb       <= '0;
      RegWrite_wb     <= 1'b0;
    end else if (stall_mem) begin
      RegWrite_wb <= 1'b0;
    end else begin
      RegWriteData_wb <= MemtoReg_mem ? load_ext : ALUResult_mem;
      rdAddr_wb       <= rdAddr_mem;
      RegWrite_wb     <= wb_rw;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected WB writes queued at issue, popped when RegWrite_wb fires.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUResult_ex, MemWriteData_ex;
  logic [4:0]  rdAddr_ex;
  logic        RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex;
  logic [2:0]  funct3_ex;
  logic [31:0] ALUResult_mem;
  logic [4:0]  rdAddr_mem;
  logic        RegWrite_mem, stall_mem, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] RegWriteData_wb;
  logic [4:0]  rdAddr_wb;
  logic        RegWrite_wb, bus_err_mem;

  mem_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .ALUResult_ex(ALUResult_ex), .MemWriteData_ex(MemWriteData_ex),
    .rdAddr_ex(rdAddr_ex), .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex),
    .MemWrite_ex(MemWrite_ex), .MemtoReg_ex(MemtoReg_ex), .funct3_ex(funct3_ex),
    .ALUResult_mem(ALUResult_mem), .rdAddr_mem(rdAddr_mem), .RegWrite_mem(RegWrite_mem),
    .stall_mem(stall_mem), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .RegWriteData_wb(RegWriteData_wb), .rdAddr_wb(rdAddr_wb), .RegWrite_wb(RegWrite_wb),
    .bus_err_mem(bus_err_mem)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  int stalls, errs, reqs, wbw;
  logic [31:0] c_be, c_wd, c_addr, c_alu, c_rd;
  logic c_we;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && RegWrite_wb) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_data", RegWriteData_wb, e.d);
        chk("wb_rd", {27'd0, rdAddr_wb}, {27'd0, e.rd});
      end
    end
  end

  task automatic clear_ex();
    ALUResult_ex = '0; MemWriteData_ex = '0; rdAddr_ex = '0;
    RegWrite_ex = 0; MemRead_ex = 0; MemWrite_ex = 0; MemtoReg_ex = 0; funct3_ex = '0;
  endtask

  // Called just after a rising edge; returns just after the edge that moves the op into WB.
  // ack_delay < 0 means the memory never acknowledges.
  task automatic run_op(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mw, input logic m2r,
                        input logic [2:0] f3, input int ack_delay, input logic [31:0] rdata);
    bit done;
    ALUResult_ex = alu; MemWriteData_ex = wd; rdAddr_ex = rd;
    RegWrite_ex = rw; MemRead_ex = mr; MemWrite_ex = mw; MemtoReg_ex = m2r; funct3_ex = f3;
    @(posedge clk); #1;
    clear_ex();
    stalls = 0; errs = 0; reqs = 0; wbw = 0; done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      dmem_ack = (k == ack_delay);
      dmem_rdata = rdata;
      @(negedge clk);
      if (k == 0) begin
        c_be = {28'd0, dmem_be}; c_wd = dmem_wdata; c_addr = dmem_addr; c_we = dmem_we;
        c_alu = ALUResult_mem; c_rd = {27'd0, rdAddr_mem};
      end
      if (k > 0 && RegWrite_wb) wbw++;
      if (dmem_req) reqs++;
      if (stall_mem) stalls++;
      if (bus_err_mem) errs++;
      done = !stall_mem;
      @(posedge clk); #1;
    end
    dmem_ack = 0;
    if (!done) chk("op_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    reset = 1; dmem_ack = 0; dmem_rdata = '0;
    clear_ex();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wbdata", RegWriteData_wb, 32'h0);
    chk("rst_wbvld", {31'd0, RegWrite_wb}, 32'd0);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall_mem}, 32'd0);
    chk("rst_be", {28'd0, dmem_be}, 32'd0);
    @(posedge clk); #1;
    reset = 0;

    // non-memory ALU op
    sb.push_back('{32'h1234, 5'd5});
    run_op(32'h1234, 32'h0, 5'd5, 1, 0, 0, 0, 3'b000, -1, 32'h0);
    chk("alu_fwd", c_alu, 32'h1234);
    chk("alu_fwd_rd", c_rd, 32'd5);
    chk("alu_noreq", reqs, 0);
    @(negedge clk);
    chk("alu_wb_lat", {31'd0, RegWrite_wb}, 32'd1);
    @(posedge clk); #1;

    // LB / LBU with same-cycle ack
    sb.push_back('{32'hFFFF_FF80, 5'd6});
    run_op(32'h1003, 32'h0, 5'd6, 1, 1, 0, 1, 3'b000, 0, 32'h80FF_0000);
    chk("lb_stall", stalls, 0);
    chk("lb_req", reqs, 1);
    chk("lb_addr", c_addr, 32'h1000);
    sb.push_back('{32'h0000_0080, 5'd6});
    run_op(32'h1003, 32'h0, 5'd6, 1, 1, 0, 1, 3'b100, 0, 32'h80FF_0000);
    chk("lbu_stall", stalls, 0);

    // LH / LHU, including a force-aligned odd address, one wait cycle
    sb.push_back('{32'hFFFF_8001, 5'd8});
    run_op(32'h4002, 32'h0, 5'd8, 1, 1, 0, 1, 3'b001, 1, 32'h8001_1234);
    chk("lh_stall", stalls, 1);
    sb.push_back('{32'h0000_8001, 5'd8});
    run_op(32'h4003, 32'h0, 5'd8, 1, 1, 0, 1, 3'b101, 0, 32'h8001_1234);
    sb.push_back('{32'h0000_1234, 5'd8});
    run_op(32'h4000, 32'h0, 5'd8, 1, 1, 0, 1, 3'b101, 0, 32'h8001_1234);
    sb.push_back('{32'hDEAD_BEEF, 5'd10});
    run_op(32'h5001, 32'h0, 5'd10, 1, 1, 0, 1, 3'b010, 0, 32'hDEAD_BEEF);

    // SH with 3-cycle ack delay
    run_op(32'h2002, 32'hAAAA_BEEF, 5'd0, 0, 0, 1, 0, 3'b001, 3, 32'h0);
    chk("sh_be", c_be, 32'hC);
    chk("sh_wdata", c_wd, 32'hBEEF_BEEF);
    chk("sh_addr", c_addr, 32'h2000);
    chk("sh_we", {31'd0, c_we}, 32'd1);
    chk("sh_stall", stalls, 3);
    chk("sh_bubbles", wbw, 0);

    // SB lane steering; read+write treated as a full-word store
    run_op(32'h6001, 32'h1234_5678, 5'd0, 0, 0, 1, 0, 3'b000, 0, 32'h0);
    chk("sb_be", c_be, 32'h2);
    chk("sb_wdata", c_wd, 32'h7878_7878);
    run_op(32'h7000, 32'h1122_3344, 5'd0, 0, 1, 1, 0, 3'b010, 0, 32'h0);
    chk("rw_we", {31'd0, c_we}, 32'd1);
    chk("sw_be", c_be, 32'hF);
    chk("sw_wdata", c_wd, 32'h1122_3344);

    // LW with no ack: timeout, zero write-back, then pipeline resumes
    sb.push_back('{32'h0, 5'd7});
    run_op(32'h8000, 32'h0, 5'd7, 1, 1, 0, 1, 3'b010, -1, 32'h5555_5555);
    chk("to_stall", stalls, 16);
    chk("to_buserr", errs, 1);
    sb.push_back('{32'hCAFE, 5'd9});
    run_op(32'hCAFE, 32'h0, 5'd9, 1, 0, 0, 0, 3'b000, -1, 32'h0);
    chk("resume_stall", stalls, 0);

    // reset while waiting, late ack ignored
    ALUResult_ex = 32'h9000; rdAddr_ex = 5'd11; RegWrite_ex = 1; MemRead_ex = 1;
    MemtoReg_ex = 1; funct3_ex = 3'b010;
    @(posedge clk); #1;
    clear_ex();
    @(negedge clk);
    chk("rw_req", {31'd0, dmem_req}, 32'd1);
    chk("rw_stall", {31'd0, stall_mem}, 32'd1);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0; dmem_ack = 1; dmem_rdata = 32'h7777_7777;
    @(negedge clk);
    chk("rw_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("rw_stall_drop", {31'd0, stall_mem}, 32'd0);
    chk("rw_alu_mem", ALUResult_mem, 32'h0);
    chk("rw_wbdata", RegWriteData_wb, 32'h0);
    chk("rw_wbvld", {31'd0, RegWrite_wb}, 32'd0);
    chk("rw_buserr", {31'd0, bus_err_mem}, 32'd0);
    @(posedge clk); #1;
    dmem_ack = 0;
    @(negedge clk);
    chk("rw_nowb", {31'd0, RegWrite_wb}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("sb_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
